// File: rtl/demux1to2_l2_pkg.sv
// Shared definitions for the L2 receive-side demux: FSM state encoding and default sizes.
package demux1to2_l2_pkg;

  typedef enum logic {
    ST_WAIT0 = 1'b0,
    ST_WAIT1 = 1'b1
  } state_e;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned GAP_MAX_DEF = 15;

  function automatic int unsigned gap_cnt_w(input int unsigned gap_max);
    return $clog2(gap_max + 1);
  endfunction

endpackage

// File: rtl/demux1to2_l2_gap_timer.sv
// Idle-cycle counter between a lane0 word and its lane1 partner; expire_o is a
// combinational pulse on the idle cycle that reaches the limit.
module demux1to2_l2_gap_timer
  import demux1to2_l2_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_o = enable_i && (cnt_q == (limit_i - ONE));
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux1to2_l2.sv
// Splits the interleaved lane0/lane1 byte stream back into paired lanes, skipping
// idle cycles and dropping a lane0 word whose partner does not arrive in time.
module demux1to2_l2
  import demux1to2_l2_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned GAP_MAX = GAP_MAX_DEF
) (
  input  logic              clk_4f_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              valid_in_i,
  output logic [DATA_W-1:0] data_out0_o,
  output logic [DATA_W-1:0] data_out1_o,
  output logic              valid_out0_o,
  output logic              valid_out1_o,
  output logic              selector_o,
  output logic              orphan_o
);

  localparam int unsigned      CNT_W = gap_cnt_w(GAP_MAX);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(GAP_MAX);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] dout0_q, dout0_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;
  logic              vld_q, vld_d;
  logic              orphan_q, orphan_d;
  logic              gap_clear, gap_en, gap_expire;

  demux1to2_l2_gap_timer #(
    .CNT_W(CNT_W)
  ) u_gap_timer (
    .clk_i   (clk_4f_i),
    .rst_i   (reset_i),
    .clear_i (gap_clear),
    .enable_i(gap_en),
    .limit_i (LIMIT),
    .expire_o(gap_expire)
  );

  // The timer only counts on idle WAIT1 cycles, so a lane1 word at the limit pairs.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    dout0_d   = dout0_q;
    dout1_d   = dout1_q;
    vld_d     = 1'b0;
    orphan_d  = 1'b0;
    gap_clear = 1'b0;
    gap_en    = 1'b0;
    case (state_q)
      ST_WAIT0: begin
        if (valid_in_i) begin
          hold_d    = data_in_i;
          gap_clear = 1'b1;
          state_d   = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (valid_in_i) begin
          dout0_d = hold_q;
          dout1_d = data_in_i;
          vld_d   = 1'b1;
          state_d = ST_WAIT0;
        end else begin
          gap_en = 1'b1;
          if (gap_expire) begin
            orphan_d = 1'b1;
            hold_d   = '0;
            state_d  = ST_WAIT0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_4f_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_WAIT0;
      hold_q   <= '0;
      dout0_q  <= '0;
      dout1_q  <= '0;
      vld_q    <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      dout0_q  <= dout0_d;
      dout1_q  <= dout1_d;
      vld_q    <= vld_d;
      orphan_q <= orphan_d;
    end
  end

  assign data_out0_o  = dout0_q;
  assign data_out1_o  = dout1_q;
  assign valid_out0_o = vld_q;
  assign valid_out1_o = vld_q;
  assign selector_o   = (state_q == ST_WAIT1);
  assign orphan_o     = orphan_q;

endmodule

// File: tb/tb_demux1to2_l2.sv
// Bench for demux1to2_l2: directed vector table, reset sequence and a randomized
// interleaved stream checked through a pair scoreboard.
module tb_demux1to2_l2;

  localparam int unsigned DW  = 8;
  localparam int unsigned GAP = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          vin;
  logic [DW-1:0] d0, d1;
  logic          v0, v1, sel, orph;

  demux1to2_l2 #(
    .DATA_W (DW),
    .GAP_MAX(GAP)
  ) dut (
    .clk_4f_i    (clk),
    .reset_i     (rst),
    .data_in_i   (din),
    .valid_in_i  (vin),
    .data_out0_o (d0),
    .data_out1_o (d1),
    .valid_out0_o(v0),
    .valid_out1_o(v1),
    .selector_o  (sel),
    .orphan_o    (orph)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          sel;
    logic          vout;
    logic          orph;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } vec_t;

  vec_t             vecs[$];
  logic [2*DW-1:0]  sb[$];
  int               pass_cnt = 0;
  int               total_cnt = 0;
  int               orphan_seen = 0;
  logic             mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic v, input logic [DW-1:0] d, input logic s, input logic vo,
                     input logic o, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    vec_t r;
    r.v = v; r.d = d; r.sel = s; r.vout = vo; r.orph = o; r.d0 = e0; r.d1 = e1;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    vin = v;
    din = d;
  endtask

  // Pair scoreboard for the randomized stream.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (orph) orphan_seen++;
        if (v0 || v1) begin
          if (sb.size() == 0) begin
            check("t6_spurious_pair", {v1, d0, d1}, 32'h0);
          end else begin
            check("t6_pair", {v0, v1, d0, d1}, {2'b11, sb.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a, b;
    rst = 1'b1;
    vin = 1'b0;
    din = '0;

    // Stimulus table: expected outputs are those seen just after the sampling edge.
    add(1, 8'hA1, 1, 0, 0, 8'h00, 8'h00);
    add(1, 8'hB2, 0, 1, 0, 8'hA1, 8'hB2);
    add(0, 8'hEE, 0, 0, 0, 8'hA1, 8'hB2);
    add(1, 8'hC3, 1, 0, 0, 8'hA1, 8'hB2);
    add(0, 8'hEE, 1, 0, 0, 8'hA1, 8'hB2);
    add(0, 8'hEE, 1, 0, 0, 8'hA1, 8'hB2);
    add(1, 8'hD4, 0, 1, 0, 8'hC3, 8'hD4);
    add(1, 8'hE5, 1, 0, 0, 8'hC3, 8'hD4);
    for (int i = 0; i < GAP - 1; i++) add(0, 8'hEE, 1, 0, 0, 8'hC3, 8'hD4);
    add(1, 8'hF6, 0, 1, 0, 8'hE5, 8'hF6);
    add(1, 8'h17, 1, 0, 0, 8'hE5, 8'hF6);
    for (int i = 0; i < GAP - 1; i++) add(0, 8'hEE, 1, 0, 0, 8'hE5, 8'hF6);
    add(0, 8'hEE, 0, 0, 1, 8'hE5, 8'hF6);
    add(0, 8'hEE, 0, 0, 0, 8'hE5, 8'hF6);
    add(1, 8'hC3, 1, 0, 0, 8'hE5, 8'hF6);
    add(1, 8'hD4, 0, 1, 0, 8'hC3, 8'hD4);
    add(1, 8'h11, 1, 0, 0, 8'hC3, 8'hD4);
    add(1, 8'h22, 0, 1, 0, 8'h11, 8'h22);
    add(1, 8'h33, 1, 0, 0, 8'h11, 8'h22);
    add(1, 8'h44, 0, 1, 0, 8'h33, 8'h44);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {sel, v0, v1, orph, d0, d1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {sel, v0, v1, orph, d0, d1},
            {vecs[i].sel, vecs[i].vout, vecs[i].vout, vecs[i].orph, vecs[i].d0, vecs[i].d1});
    end

    // Asynchronous reset with a lane0 word pending.
    drive(1, 8'h55);
    @(posedge clk);
    #2;
    check("pre_reset_sel", {31'h0, sel}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_reset", {sel, v0, v1, orph, d0, d1}, 32'h0);
    @(negedge clk);
    vin = 1'b0;
    rst = 1'b0;
    drive(1, 8'h66);
    @(posedge clk);
    #1;
    check("post_reset_lane0", {sel, v0, orph}, {1'b1, 1'b0, 1'b0});
    drive(1, 8'h77);
    @(posedge clk);
    #1;
    check("post_reset_pair", {sel, v0, v1, orph, d0, d1}, {4'b0110, 8'h66, 8'h77});
    drive(0, 8'hEE);

    // Randomized interleaved stream with legal gaps.
    mon_en = 1'b1;
    for (int p = 0; p < 16; p++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) drive(0, 8'($urandom));
      a = 8'($urandom);
      b = 8'($urandom);
      sb.push_back({a, b});
      drive(1, a);
      for (int g = 0; g < int'($urandom_range(0, GAP - 1)); g++) drive(0, 8'($urandom));
      drive(1, b);
    end
    drive(0, 8'h00);
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    mon_en = 1'b0;
    check("t6_drained", sb.size(), 32'h0);
    check("t6_no_orphan", orphan_seen, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
